// File: rtl/pcpi_mul_pkg.sv
// Shared definitions for the iterative PCPI RV32M multiplier.
// Holds the decode constants, the FSM state and operation enums, and the
// helper that gives the number of RUN cycles an operation needs.
package pcpi_mul_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  // MUL only needs the low 32 product bits, so only 32 bits of B matter;
  // the high-half ops walk all 64 bits of the extended B.
  function automatic logic [6:0] iter_count(op_e op, int steps);
    int bits;
    bits = (op == OP_MUL) ? 32 : 64;
    return 7'(bits / steps);
  endfunction

endpackage

// File: rtl/pcpi_mul_step.sv
// Combinational shift-add slice: consumes STEPS bits of B (LSB first) per
// invocation and adds the masked, shifted A for each set bit.
// Ports:
//   acc_i  : running 64-bit accumulator
//   a_i    : multiplicand, already shifted to the current base bit position
//   b_i    : remaining multiplier bits (bit 0 is the next bit to consume)
//   mask_i : partial-product mask, low K bits cleared in approximate mode
//   acc_o  : accumulator after this slice
//   a_o    : A shifted left by STEPS for the next slice
//   b_o    : B shifted right by STEPS for the next slice
module pcpi_mul_step import pcpi_mul_pkg::*; #(
  parameter int STEPS = 1
) (
  input  logic [63:0] acc_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] mask_i,
  output logic [63:0] acc_o,
  output logic [63:0] a_o,
  output logic [63:0] b_o
);

  // Because a_i carries the absolute bit offset, masking here truncates
  // partial-product bits in absolute product position, as intended.
  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < STEPS; i++) begin
      if (b_i[i]) begin
        acc_o = acc_o + ((a_i << i) & mask_i);
      end
    end
    a_o = a_i << STEPS;
    b_o = b_i >> STEPS;
  end

endmodule

// File: rtl/pcpi_mul_approx.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) on the PCPI
// co-processor interface, with configurable bits per cycle, a runtime
// approximate mode truncating low partial-product bits, and a zero-operand
// early-out.
// Handshake: an instruction is claimed in the cycle pcpi_valid is high in
// IDLE with a matching decode; pcpi_wait stays high from the next cycle
// until the one-cycle pcpi_ready/pcpi_wr pulse; dropping pcpi_valid while
// running abandons the operation with no result.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pcpi_valid/insn/rs1/rs2 : instruction offer from the core
//   approx_en, approx_lsb : approximate mode request and width K (sampled at accept)
//   pcpi_wr, pcpi_rd      : result strobe and value
//   pcpi_wait, pcpi_ready : claim and completion
//   busy                  : high while iterating
//   dbg_state_o           : current FSM state
module pcpi_mul_approx import pcpi_mul_pkg::*; #(
  parameter int STEPS_AT_ONCE  = 1,
  parameter int APPROX_MAX_LSB = 16,
  parameter int EARLY_OUT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  input  logic        approx_en,
  input  logic [4:0]  approx_lsb,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [63:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mask_q, mask_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        eo_q, eo_d;
  logic [31:0] rd_q, rd_d;

  logic [63:0] step_acc, step_a, step_b;
  logic        dec_hit;
  op_e         dec_op;
  logic [6:0]  k_sel;
  logic [6:0]  n_iter;

  // Register/source fields of the instruction play no part in the multiply.
  logic unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign dec_hit = (pcpi_insn[6:0] == OPCODE_OP) &&
                   (pcpi_insn[31:25] == FUNCT7_MULDIV) &&
                   !pcpi_insn[14];

  always_comb begin
    case (pcpi_insn[14:12])
      FUNCT3_MULH:   dec_op = OP_MULH;
      FUNCT3_MULHSU: dec_op = OP_MULHSU;
      FUNCT3_MULHU:  dec_op = OP_MULHU;
      default:       dec_op = OP_MUL;
    endcase
  end

  // Truncation width, clamped to APPROX_MAX_LSB; zero when exact.
  always_comb begin
    k_sel = 7'd0;
    if (approx_en) begin
      if ({2'b00, approx_lsb} > 7'(APPROX_MAX_LSB)) k_sel = 7'(APPROX_MAX_LSB);
      else                                          k_sel = {2'b00, approx_lsb};
    end
  end

  assign n_iter = iter_count(op_q, STEPS_AT_ONCE);

  pcpi_mul_step #(.STEPS(STEPS_AT_ONCE)) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .mask_i (mask_q),
    .acc_o  (step_acc),
    .a_o    (step_a),
    .b_o    (step_b)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    eo_d    = eo_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (pcpi_valid && dec_hit) begin
          state_d = ST_RUN;
          op_d    = dec_op;
          a_d     = (dec_op == OP_MULH || dec_op == OP_MULHSU) ?
                    {{32{pcpi_rs1[31]}}, pcpi_rs1} : {32'd0, pcpi_rs1};
          b_d     = (dec_op == OP_MULH) ?
                    {{32{pcpi_rs2[31]}}, pcpi_rs2} : {32'd0, pcpi_rs2};
          mask_d  = ~((64'd1 << k_sel) - 64'd1);
          acc_d   = 64'd0;
          cnt_d   = 7'd0;
          eo_d    = (EARLY_OUT != 0) && (pcpi_rs1 == 32'd0 || pcpi_rs2 == 32'd0);
        end
      end
      ST_RUN: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else if (eo_q) begin
          state_d = ST_DONE;
          rd_d    = 32'd0;
        end else begin
          acc_d = step_acc;
          a_d   = step_a;
          b_d   = step_b;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == n_iter - 7'd1) begin
            state_d = ST_DONE;
            rd_d    = (op_q == OP_MUL) ? step_acc[31:0] : step_acc[63:32];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      acc_q   <= 64'd0;
      mask_q  <= 64'd0;
      cnt_q   <= 7'd0;
      eo_q    <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      eo_q    <= eo_d;
      rd_q    <= rd_d;
    end
  end

  assign pcpi_ready  = (state_q == ST_DONE);
  assign pcpi_wr     = (state_q == ST_DONE);
  assign pcpi_wait   = (state_q != ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign pcpi_rd     = rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pcpi_mul_approx.sv
// Bench for pcpi_mul_approx: three instances with different parameter sets
// share operand inputs but each has its own pcpi_valid. A timeline model
// (accept cycle, latency, end cycle, result) predicts every output on every
// cycle; literal expectations pin the arithmetic.
module tb_pcpi_mul_approx;

  localparam int S_OF[3]    = '{1, 8, 1};
  localparam int MAXL_OF[3] = '{16, 31, 16};
  localparam int EO_OF[3]   = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic        valid[3];
  logic [31:0] insn, rs1, rs2;
  logic        aen;
  logic [4:0]  alsb;
  logic        wr_w[3], wait_w[3], ready_w[3], busy_w[3];
  logic [31:0] rd_w[3];
  logic [1:0]  st_w[3];

  always #5 clk = ~clk;

  pcpi_mul_approx #(.STEPS_AT_ONCE(1), .APPROX_MAX_LSB(16), .EARLY_OUT(1)) u_d0 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[0]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .approx_en(aen), .approx_lsb(alsb),
    .pcpi_wr(wr_w[0]), .pcpi_rd(rd_w[0]), .pcpi_wait(wait_w[0]),
    .pcpi_ready(ready_w[0]), .busy(busy_w[0]), .dbg_state_o(st_w[0]));

  pcpi_mul_approx #(.STEPS_AT_ONCE(8), .APPROX_MAX_LSB(31), .EARLY_OUT(1)) u_d1 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[1]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .approx_en(aen), .approx_lsb(alsb),
    .pcpi_wr(wr_w[1]), .pcpi_rd(rd_w[1]), .pcpi_wait(wait_w[1]),
    .pcpi_ready(ready_w[1]), .busy(busy_w[1]), .dbg_state_o(st_w[1]));

  pcpi_mul_approx #(.STEPS_AT_ONCE(1), .APPROX_MAX_LSB(16), .EARLY_OUT(0)) u_d2 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[2]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .approx_en(aen), .approx_lsb(alsb),
    .pcpi_wr(wr_w[2]), .pcpi_rd(rd_w[2]), .pcpi_wait(wait_w[2]),
    .pcpi_ready(ready_w[2]), .busy(busy_w[2]), .dbg_state_o(st_w[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // Timeline model per instance.
  int          t_acc[3];
  int          n_lat[3];
  int          end_cyc[3];
  logic [31:0] res[3];
  logic [31:0] exp_rd[3];

  // Product per RV32M rules; in approximate mode each partial product
  // A<<i loses its low K bits before summation.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] x, logic [31:0] y,
                                        logic en, logic [4:0] lsb, int maxl);
    logic [63:0] a, b, p, m;
    int k;
    a = (op == 2'd1 || op == 2'd2) ? {{32{x[31]}}, x} : {32'd0, x};
    b = (op == 2'd1) ? {{32{y[31]}}, y} : {32'd0, y};
    k = en ? ((int'(lsb) > maxl) ? maxl : int'(lsb)) : 0;
    if (k == 0) begin
      p = a * b;
    end else begin
      m = ~((64'd1 << k) - 64'd1);
      p = 64'd0;
      for (int i = 0; i < 64; i++) if (b[i]) p = p + ((a << i) & m);
    end
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Compare process: every cycle, every instance.
  bit rst_seen = 1'b0;
  always @(negedge clk) begin : cmp
    int k;
    bit act;
    logic e_busy, e_wait, e_rdy;
    if (rst_seen) for (int d = 0; d < 3; d++) exp_rd[d] = 32'd0;
    rst_seen = reset;
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        k      = cyc - t_acc[d];
        act    = (t_acc[d] >= 0) && (k >= 1) && (cyc <= end_cyc[d]);
        e_busy = act && (k <= n_lat[d]);
        e_wait = act && (k <= n_lat[d] + 1);
        e_rdy  = act && (k == n_lat[d] + 1);
        if (e_rdy) exp_rd[d] = res[d];
        total++;
        if ({busy_w[d], wait_w[d], ready_w[d], wr_w[d], rd_w[d]} !==
            {e_busy, e_wait, e_rdy, e_rdy, exp_rd[d]}) begin
          bad++;
          $display("FAIL cycle_check dut%0d cyc=%0d: got busy=%b wait=%b ready=%b wr=%b rd=%h, want busy=%b wait=%b ready=%b wr=%b rd=%h",
                   d, cyc, busy_w[d], wait_w[d], ready_w[d], wr_w[d], rd_w[d],
                   e_busy, e_wait, e_rdy, e_rdy, exp_rd[d]);
        end
      end
    end
  end

  // Driver tasks: all are entered 1 time unit after a rising edge.
  task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic en, input logic [4:0] lsb);
    insn     = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    rs1      = a;
    rs2      = b;
    aen      = en;
    alsb     = lsb;
    valid[d] = 1'b1;
    t_acc[d] = cyc;
    if (EO_OF[d] != 0 && (a == 32'd0 || b == 32'd0)) n_lat[d] = 1;
    else n_lat[d] = ((f3 == 3'b000) ? 32 : 64) / S_OF[d];
    end_cyc[d] = cyc + n_lat[d] + 1;
    res[d]     = model(f3[1:0], a, b, en, lsb, MAXL_OF[d]);
  endtask

  task automatic finish_op(input int d, input bit chk, input logic [31:0] lit,
                           input string nm, input bit keep);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    // Inputs after accept must not influence the running operation.
    aen  = 1'($urandom_range(0, 1));
    alsb = 5'($urandom_range(0, 31));
    rs1  = $urandom;
    rs2  = $urandom;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = ready_w[d];
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout dut%0d: got no ready, want ready", nm, d);
    end
    if (chk) begin
      total++;
      if (rd_w[d] !== lit) begin
        bad++;
        $display("FAIL %s dut%0d: got rd=%h, want %h", nm, d, rd_w[d], lit);
      end
    end
    if (!keep) valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input int d, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic en, input logic [4:0] lsb,
                     input bit chk, input logic [31:0] lit, input string nm);
    issue(d, f3, a, b, en, lsb);
    finish_op(d, chk, lit, nm, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    insn = 32'd0; rs1 = 32'd0; rs2 = 32'd0; aen = 1'b0; alsb = 5'd0;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; t_acc[d] = -1; n_lat[d] = 0; end_cyc[d] = -1;
      res[d] = 32'd0; exp_rd[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) begin
      run(d, 3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, 5'd0, 1'b1, 32'hFFFFFFEB, "mul_7x-3");
      run(d, 3'b001, 32'h80000000, 32'h80000000, 1'b0, 5'd0, 1'b1, 32'h40000000, "mulh_min");
      run(d, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFE, "mulhu_max");
      run(d, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFF, "mulhsu_m1");
      run(d, 3'b000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 5'd8, 1'b1, 32'hFFFE0001, "mul_exact");
      run(d, 3'b000, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 5'd8, 1'b1, 32'hFFFDF900, "mul_k8");
      // K clamps to 16 on the 16-limit builds; the 31-limit build keeps K=31
      // which wipes every partial-product bit below 2^31 here.
      run(d, 3'b000, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 5'd31, 1'b1,
          (MAXL_OF[d] == 16) ? 32'hFFEF0000 : 32'h00000000, "mul_k31");
      run(d, 3'b000, 32'd0, 32'h12345678, 1'b0, 5'd0, 1'b1, 32'd0, "mul_zero");
      run(d, 3'b001, 32'hDEADBEEF, 32'd0, 1'b0, 5'd0, 1'b1, 32'd0, "mulh_zero");
      run(d, 3'b001, 32'hFFFFFFF9, 32'd3, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFF, "mulh_neg");
      run(d, 3'b001, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5'd12, 1'b0, 32'd0, "mulh_apx");
      run(d, 3'b010, 32'h80000001, 32'h7FFFFFFF, 1'b1, 5'd20, 1'b0, 32'd0, "mulhsu_apx");
      for (int i = 0; i < 3; i++)
        run(d, {1'b0, 2'($urandom_range(0, 3))}, $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0, 32'd0, "rand");
    end

    // Back-to-back: second accept in the first IDLE cycle after DONE.
    for (int d = 0; d < 2; d++) begin
      issue(d, 3'b000, 32'd3, 32'd5, 1'b0, 5'd0);
      finish_op(d, 1'b1, 32'd15, "b2b_first", 1'b1);
      issue(d, 3'b000, 32'd6, 32'd7, 1'b0, 5'd0);
      finish_op(d, 1'b1, 32'd42, "b2b_second", 1'b0);
      @(posedge clk); #1;
    end

    // Abort: pcpi_valid drops at T+5.
    for (int d = 0; d < 3; d++) begin
      issue(d, 3'b001, 32'h11111111, 32'h22222222, 1'b0, 5'd0);
      repeat (5) @(posedge clk);
      #1;
      valid[d]   = 1'b0;
      end_cyc[d] = cyc;
      repeat (8) @(posedge clk);
      #1;
    end

    // Reset at T+10 of a MULH.
    issue(0, 3'b001, 32'h40000000, 32'h40000000, 1'b0, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    reset      = 1'b1;
    end_cyc[0] = cyc;
    @(posedge clk); #1;
    reset    = 1'b0;
    valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Divide and non-OP opcodes are never claimed.
    insn  = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011};
    rs1   = 32'd9; rs2 = 32'd3;
    for (int d = 0; d < 3; d++) valid[d] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    insn = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011};
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
